nibble_sub: RTL

NIBBLE_SUB -- requirements
Module: nibble_sub

---
 rtl/nibble_sub_if.sv | 29 ++
 rtl/nibble_sub.sv | 120 ++++++++++++
 2 files changed

// File: rtl/nibble_sub_if.sv
// Operand/result bundle for the nibble-serial subtractor.
// Latency: none (wires only).
// Backpressure: none; the requester watches busy/done before issuing start.
interface nibble_sub_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;
  logic         Z;

  modport master (
    output start, X, Y, Bin,
    input  busy, done, D, Bout, V, Z
  );

  modport slave (
    input  start, X, Y, Bin,
    output busy, done, D, Bout, V, Z
  );
endinterface

// File: rtl/nibble_sub.sv
// Nibble-serial subtractor D = X - Y - Bin using 4-bit borrow look-ahead per step.
// Latency: done pulses NIBBLES cycles after the accepting edge; then one IDLE cycle.
// Backpressure: none; start is only sampled in IDLE and ignored while BUSY/DONE.
module nibble_sub #(
  parameter int NIBBLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  nibble_sub_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q;
  state_t        state_nx;

  logic [W-1:0]  x_q;
  logic [W-1:0]  y_q;
  logic [W-1:0]  res_q;
  logic [IW-1:0] idx_q;
  logic          brw_q;

  logic [W-1:0]  d_q;
  logic          bout_q;
  logic          v_q;
  logic          z_q;

  logic          accept;
  logic          last_step;
  logic [3:0]    xn;
  logic [3:0]    yn;
  logic [3:0]    g;
  logic [3:0]    p;
  logic [4:0]    b;
  logic [3:0]    dn;
  logic [W-1:0]  res_nx;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_step = (state_q == BUSY) && (idx_q == LAST);

  // State register; reset drops any in-flight operation without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state: accept in IDLE, leave BUSY after the last nibble, DONE lasts one cycle.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_nx = BUSY;
      BUSY:    if (idx_q == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One nibble of borrow look-ahead: all four borrows expanded from the nibble borrow-in.
  always_comb begin
    xn = x_q[{idx_q, 2'b00} +: 4];
    yn = y_q[{idx_q, 2'b00} +: 4];
    g  = ~xn & yn;
    p  = ~(xn ^ yn);
    b[0] = brw_q;
    b[1] = g[0] | (p[0] & brw_q);
    b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & brw_q);
    b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & brw_q);
    b[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & brw_q);
    dn = xn ^ yn ^ b[3:0];
    res_nx = res_q;
    res_nx[{idx_q, 2'b00} +: 4] = dn;
  end

  // Operand capture, per-nibble accumulation and result/flag update on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      res_q  <= '0;
      idx_q  <= '0;
      brw_q  <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      v_q    <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      if (accept) begin
        x_q   <= bus.X;
        y_q   <= bus.Y;
        idx_q <= '0;
        brw_q <= bus.Bin;
      end else if (state_q == BUSY) begin
        res_q <= res_nx;
        brw_q <= b[4];
        idx_q <= idx_q + 1'b1;
      end
      if (last_step) begin
        d_q    <= res_nx;
        bout_q <= b[4];
        v_q    <= (x_q[W-1] ^ y_q[W-1]) & (x_q[W-1] ^ res_nx[W-1]);
        z_q    <= (res_nx == '0);
      end
    end
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.done = (state_q == DONE);
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
endmodule
